trap_shaper_sequencer: RTL and testbench
========================================

Name:
trap_shaper_sequencer

Overview:
Controller for the trapezoidal shaping filter (k, l, M datapath). It holds and validates the shaper configuration and clears the filter on every config change. It waits out the pipeline flush, then runs a threshold-triggered peak detector on the filter output. Each detected pulse is emitted as one event (amplitude, timestamp, width) over a valid/ready handshake toward the readout.

Parameters:
DATA_W, 16, filter sample width (signed)
KL_W, 7, width of k and l config fields
M_W, 8, width of M config field
TS_W, 32, sample timestamp width
WIDTH_W, 8, pulse width counter width (saturating)
FLUSH_EXTRA, 8, extra samples waited beyond k+l after a clear
K_DEF, 4, reset value of k
L_DEF, 10, reset value of l
M_DEF, 20, reset value of M
THR_DEF, 100, reset value of threshold

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_wr  in  1  one-cycle config write strobe
cfg_k  in  KL_W  requested k
cfg_l  in  KL_W  requested l
cfg_m  in  M_W  requested M
cfg_thr  in  DATA_W  signed trigger threshold
cfg_busy  out  1  high while clearing or flushing
cfg_err  out  1  one-cycle pulse when a write is rejected
filt_clear  out  1  one-cycle clear to the filter
filt_k  out  KL_W  active k
filt_l  out  KL_W  active l
filt_m  out  M_W  active M
filt_valid  in  1  filter output sample strobe
filt_data  in  DATA_W  signed filter output
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_amp  out  DATA_W  signed peak amplitude
evt_ts  out  TS_W  sample index of the peak
evt_width  out  WIDTH_W  number of samples above threshold
evt_dropped  out  1  at least one pulse was lost before this event

Behaviour:
- Reset values:
  - filt_k/l/m and threshold = K_DEF/L_DEF/M_DEF/THR_DEF.
  - All other outputs 0; timestamp counter 0; state IDLE.
- Leaving IDLE: IDLE moves to CLEAR on the first cycle after reset.
- Config validation:
  - A cfg_wr is valid if cfg_k != 0 and cfg_l >= cfg_k.
  - Invalid write: cfg_err pulses the next cycle; config and state are unchanged.
  - Valid write: accepted in any state. Registers update the next cycle and the FSM goes to CLEAR.
- CLEAR (1 cycle):
  - filt_clear=1, cfg_busy=1.
  - Timestamp counter zeroed; sample counter loaded with k+l+FLUSH_EXTRA.
  - Next state FLUSH.
- FLUSH:
  - cfg_busy=1.
  - Sample counter decrements on each filt_valid.
  - When it reaches 0, go to ARMED; cfg_busy=0 from that cycle on.
  - A valid cfg_wr during FLUSH restarts from CLEAR with the new values.
- Timestamp:
  - Increments on every filt_valid outside CLEAR; wraps modulo 2^TS_W.
  - The timestamp of a sample is the counter value before that sample's increment.
- ARMED: on filt_valid with filt_data > thr (signed, strict), go to TRACK with amp=data, ts=timestamp, width=1.
- TRACK, on each filt_valid:
  - If data > thr: width += 1, saturating at 2^WIDTH_W-1.
  - If also data > amp: amp and ts update. On equal values the earliest peak is kept.
  - If data <= thr: go to EMIT.
- EMIT:
  - evt_valid=1 starting the cycle after the ending sample.
  - evt_amp/ts/width/dropped stay stable until the evt_valid && evt_ready cycle.
  - Next cycle: evt_valid=0, dropped flag cleared, state ARMED.
- Pulses lost during EMIT:
  - Samples are not analysed while in EMIT.
  - A rising crossing (previous sample <= thr, current > thr) sets a sticky drop flag, reported on the next event.
- Config write during TRACK or EMIT: any pending event is discarded and evt_valid drops the next cycle. The drop flag is cleared; the FSM goes to CLEAR.
- filt_valid in CLEAR: ignored, not counted.
- Reset mid-operation: all state and outputs return to reset values on the next edge.

Test Plan:
1. Reset, then cfg_wr k=4 l=10 m=20 thr=100 -> filt_clear high exactly 1 cycle; filt_k=4/l=10/m=20; cfg_busy high until 22 filt_valid samples are counted, then ARMED.
2. Armed, samples 50,150,300,250,90 at timestamps 0..4 -> one event with amp=300, ts=2, width=3, dropped=0; evt_valid rises the cycle after sample 90.
3. evt_ready held low 20 cycles while a second pulse 0,200,0 arrives -> first event fields stay stable; after the handshake, the next event reports dropped=1.
4. cfg_wr k=12 l=8 -> cfg_err 1-cycle pulse; filt_k stays 4, filt_l stays 10; no filt_clear.
5. cfg_wr (valid) during TRACK -> no event emitted, filt_clear pulses, flush recounts. Separately, reset asserted while evt_valid=1 -> evt_valid=0 next cycle.
6. 300 consecutive samples of 500, then 0 -> evt_width=255 (saturated), amp=500, ts equals the timestamp of the first sample of 500.

Source files
------------

// File: rtl/trap_shaper_sequencer.sv
// Purpose : sequencer for the trapezoidal shaper (k, l, M). It holds and validates the
//           filter config, clears and flushes the filter on each config change, then
//           detects threshold-triggered pulses and emits one event per pulse.
// Latency : config registers and cfg_err update 1 cycle after cfg_wr; evt_valid rises
//           1 cycle after the sample that ends a pulse.
// Backpressure: an event is held stable until evt_valid && evt_ready. Pulses that start
//           while an event is pending are not analysed; they set a sticky drop flag
//           that is reported with the next event.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cfg_wr/k/l/m/thr                config write strobe and requested values
//   cfg_busy, cfg_err               clear/flush in progress, rejected write pulse
//   filt_clear, filt_k/l/m          filter clear strobe and active parameters
//   filt_valid, filt_data           filter output sample stream (signed)
//   evt_valid/ready                 event handshake toward readout
//   evt_amp/ts/width/dropped        event payload
module trap_shaper_sequencer #(
   parameter int DATA_W      = 16,
   parameter int KL_W        = 7,
   parameter int M_W         = 8,
   parameter int TS_W        = 32,
   parameter int WIDTH_W     = 8,
   parameter int FLUSH_EXTRA = 8,
   parameter int K_DEF       = 4,
   parameter int L_DEF       = 10,
   parameter int M_DEF       = 20,
   parameter int THR_DEF     = 100
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_wr,
   input  logic [KL_W-1:0]          cfg_k,
   input  logic [KL_W-1:0]          cfg_l,
   input  logic [M_W-1:0]           cfg_m,
   input  logic signed [DATA_W-1:0] cfg_thr,
   output logic                     cfg_busy,
   output logic                     cfg_err,
   output logic                     filt_clear,
   output logic [KL_W-1:0]          filt_k,
   output logic [KL_W-1:0]          filt_l,
   output logic [M_W-1:0]           filt_m,
   input  logic                     filt_valid,
   input  logic signed [DATA_W-1:0] filt_data,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic signed [DATA_W-1:0] evt_amp,
   output logic [TS_W-1:0]          evt_ts,
   output logic [WIDTH_W-1:0]       evt_width,
   output logic                     evt_dropped
);

   // Wide enough for (2^KL_W-1)*2 + FLUSH_EXTRA.
   localparam int CNT_W = $clog2(2 * (2 ** KL_W) + FLUSH_EXTRA);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FLUSH,
      S_ARMED,
      S_TRACK,
      S_EMIT
   } state_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] amp;
      logic [TS_W-1:0]          ts;
      logic [WIDTH_W-1:0]       width;
      logic                     dropped;
   } evt_t;

   state_t                   state;
   state_t                   state_n;
   evt_t                     evt;
   logic signed [DATA_W-1:0] thr;
   logic [TS_W-1:0]          ts_cnt;
   logic [CNT_W-1:0]         smp_cnt;
   logic                     prev_above;
   logic                     drop_pend;
   logic                     cfg_ok;
   logic                     above;

   assign cfg_ok = cfg_wr && (cfg_k != '0) && (cfg_l >= cfg_k);
   assign above  = filt_data > thr;

   assign evt_amp     = evt.amp;
   assign evt_ts      = evt.ts;
   assign evt_width   = evt.width;
   assign evt_dropped = evt.dropped;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      filt_clear = 1'b0;
      cfg_busy   = 1'b0;
      evt_valid  = 1'b0;
      case (state)
         S_IDLE:  state_n = S_CLEAR;
         S_CLEAR: begin
            filt_clear = 1'b1;
            cfg_busy   = 1'b1;
            state_n    = S_FLUSH;
         end
         S_FLUSH: begin
            cfg_busy = 1'b1;
            // Leave on the sample that takes the counter to zero.
            if (filt_valid && smp_cnt <= CNT_W'(1)) state_n = S_ARMED;
         end
         S_ARMED: if (filt_valid && above)  state_n = S_TRACK;
         S_TRACK: if (filt_valid && !above) state_n = S_EMIT;
         S_EMIT: begin
            evt_valid = 1'b1;
            if (evt_ready) state_n = S_ARMED;
         end
         default: state_n = S_IDLE;
      endcase
      // A valid config write wins over everything, discarding any pending event.
      if (cfg_ok) state_n = S_CLEAR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_err    <= 1'b0;
         filt_k     <= KL_W'(K_DEF);
         filt_l     <= KL_W'(L_DEF);
         filt_m     <= M_W'(M_DEF);
         thr        <= DATA_W'(THR_DEF);
         ts_cnt     <= '0;
         smp_cnt    <= '0;
         prev_above <= 1'b0;
         drop_pend  <= 1'b0;
         evt        <= '0;
      end else begin
         cfg_err <= cfg_wr && !cfg_ok;
         if (cfg_ok) begin
            filt_k <= cfg_k;
            filt_l <= cfg_l;
            filt_m <= cfg_m;
            thr    <= cfg_thr;
         end

         // Samples arriving while the filter is being cleared do not exist.
         if (state == S_CLEAR) begin
            ts_cnt     <= '0;
            smp_cnt    <= CNT_W'(filt_k) + CNT_W'(filt_l) + CNT_W'(FLUSH_EXTRA);
            prev_above <= 1'b0;
         end else if (filt_valid) begin
            ts_cnt     <= ts_cnt + TS_W'(1);
            prev_above <= above;
            if (state == S_FLUSH) smp_cnt <= smp_cnt - CNT_W'(1);
         end

         // Peak capture: strict > keeps the earliest of equal maxima.
         if (filt_valid && above) begin
            if (state == S_ARMED) begin
               evt.amp   <= filt_data;
               evt.ts    <= ts_cnt;
               evt.width <= WIDTH_W'(1);
            end else if (state == S_TRACK) begin
               if (evt.width != '1) evt.width <= evt.width + WIDTH_W'(1);
               if (filt_data > evt.amp) begin
                  evt.amp <= filt_data;
                  evt.ts  <= ts_cnt;
               end
            end
         end

         // drop_pend collects crossings missed during EMIT; it is frozen into the
         // event payload when the following pulse ends so the payload stays stable.
         if (cfg_ok || state == S_CLEAR) begin
            drop_pend   <= 1'b0;
            evt.dropped <= 1'b0;
         end else begin
            if (state == S_EMIT && filt_valid && above && !prev_above) drop_pend <= 1'b1;
            if (state == S_TRACK && filt_valid && !above) begin
               evt.dropped <= drop_pend;
               drop_pend   <= 1'b0;
            end
            if (state == S_EMIT && evt_ready) evt.dropped <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_trap_shaper_sequencer.sv
// Purpose : directed self-checking bench for trap_shaper_sequencer.
// Latency : inputs are driven 1 time unit after a rising edge, outputs are read at the
//           same point, so each check sees the state produced by the preceding edge.
// Backpressure: evt_ready is driven explicitly by each scenario.
module tb_trap_shaper_sequencer;

   logic               clk;
   logic               reset;
   logic               cfg_wr;
   logic [6:0]         cfg_k;
   logic [6:0]         cfg_l;
   logic [7:0]         cfg_m;
   logic signed [15:0] cfg_thr;
   logic               cfg_busy;
   logic               cfg_err;
   logic               filt_clear;
   logic [6:0]         filt_k;
   logic [6:0]         filt_l;
   logic [7:0]         filt_m;
   logic               filt_valid;
   logic signed [15:0] filt_data;
   logic               evt_valid;
   logic               evt_ready;
   logic signed [15:0] evt_amp;
   logic [31:0]        evt_ts;
   logic [7:0]         evt_width;
   logic               evt_dropped;

   int n_cmp = 0;
   int n_bad = 0;

   trap_shaper_sequencer dut (
      .clk(clk), .reset(reset),
      .cfg_wr(cfg_wr), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_thr(cfg_thr),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .filt_clear(filt_clear), .filt_k(filt_k), .filt_l(filt_l), .filt_m(filt_m),
      .filt_valid(filt_valid), .filt_data(filt_data),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_amp(evt_amp), .evt_ts(evt_ts), .evt_width(evt_width), .evt_dropped(evt_dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [15:0] d);
      filt_valid = 1'b1;
      filt_data  = d;
      tick();
      filt_valid = 1'b0;
      filt_data  = '0;
   endtask

   task automatic write_cfg(input logic [6:0] k, input logic [6:0] l,
                            input logic [7:0] m, input logic signed [15:0] t);
      cfg_wr = 1'b1; cfg_k = k; cfg_l = l; cfg_m = m; cfg_thr = t;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (filt_k !== 7'd4)      begin n_bad++; $display("FAIL reset_k got %0d exp 4", filt_k); end
      n_cmp++; if (filt_l !== 7'd10)     begin n_bad++; $display("FAIL reset_l got %0d exp 10", filt_l); end
      n_cmp++; if (filt_m !== 8'd20)     begin n_bad++; $display("FAIL reset_m got %0d exp 20", filt_m); end
      n_cmp++; if (filt_clear !== 1'b0)  begin n_bad++; $display("FAIL reset_clear got %b exp 0", filt_clear); end
      n_cmp++; if (cfg_busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got %b exp 0", cfg_busy); end
      n_cmp++; if (cfg_err !== 1'b0)     begin n_bad++; $display("FAIL reset_err got %b exp 0", cfg_err); end
      n_cmp++; if (evt_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got %b exp 0", evt_valid); end
      n_cmp++; if ({evt_amp, evt_ts, evt_width, evt_dropped} !== 57'd0)
         begin n_bad++; $display("FAIL reset_payload got %h exp 0", {evt_amp, evt_ts, evt_width, evt_dropped}); end
   endtask

   // Auto clear after reset, then a config write during that flush restarts it.
   task automatic test_config_flush();
      int clr_cnt;
      reset = 1'b0;
      tick();
      n_cmp++; if (filt_clear !== 1'b1) begin n_bad++; $display("FAIL auto_clear got %b exp 1", filt_clear); end
      tick();
      n_cmp++; if (cfg_busy !== 1'b1)   begin n_bad++; $display("FAIL auto_flush_busy got %b exp 1", cfg_busy); end
      write_cfg(7'd4, 7'd10, 8'd20, 16'sd100);
      n_cmp++; if ({filt_k, filt_l, filt_m} !== {7'd4, 7'd10, 8'd20})
         begin n_bad++; $display("FAIL cfg_regs got %0d/%0d/%0d exp 4/10/20", filt_k, filt_l, filt_m); end
      clr_cnt = int'(filt_clear);
      for (int i = 0; i < 4; i++) begin
         tick();
         clr_cnt += int'(filt_clear);
      end
      n_cmp++; if (clr_cnt != 1) begin n_bad++; $display("FAIL clear_len got %0d cycles exp 1", clr_cnt); end
      for (int i = 0; i < 21; i++) send(16'sd0);
      n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL busy_at_21 got %b exp 1", cfg_busy); end
      send(16'sd0);
      n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL busy_at_22 got %b exp 0", cfg_busy); end
   endtask

   // Flush consumed timestamps 0..21, so this pulse sits at 22..26.
   task automatic test_single_event();
      send(16'sd50); send(16'sd150); send(16'sd300); send(16'sd250);
      n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid got %b exp 0", evt_valid); end
      send(16'sd90);
      n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL evt1_valid got %b exp 1", evt_valid); end
      n_cmp++; if (evt_amp !== 16'sd300) begin n_bad++; $display("FAIL evt1_amp got %0d exp 300", evt_amp); end
      n_cmp++; if (evt_ts !== 32'd24)    begin n_bad++; $display("FAIL evt1_ts got %0d exp 24", evt_ts); end
      n_cmp++; if (evt_width !== 8'd3)   begin n_bad++; $display("FAIL evt1_width got %0d exp 3", evt_width); end
      n_cmp++; if (evt_dropped !== 1'b0) begin n_bad++; $display("FAIL evt1_dropped got %b exp 0", evt_dropped); end
   endtask

   task automatic test_backpressure();
      logic [57:0] got_v;
      logic [57:0] exp_v;
      exp_v = {1'b1, 16'sd300, 32'd24, 8'd3, 1'b0};
      evt_ready = 1'b0;
      // Lost pulse 0,200,0 at timestamps 27..29 while the event is held.
      for (int c = 0; c < 20; c++) begin
         filt_valid = (c == 2 || c == 5 || c == 8);
         filt_data  = (c == 5) ? 16'sd200 : 16'sd0;
         tick();
         filt_valid = 1'b0;
         got_v = {evt_valid, evt_amp, evt_ts, evt_width, evt_dropped};
         n_cmp++; if (got_v !== exp_v) begin n_bad++; $display("FAIL hold_c%0d got %h exp %h", c, got_v, exp_v); end
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL hs1_valid got %b exp 0", evt_valid); end
      send(16'sd150); send(16'sd0);
      got_v = {evt_valid, evt_amp, evt_ts, evt_width, evt_dropped};
      exp_v = {1'b1, 16'sd150, 32'd30, 8'd1, 1'b1};
      n_cmp++; if (got_v !== exp_v) begin n_bad++; $display("FAIL evt2 got %h exp %h", got_v, exp_v); end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      n_cmp++; if ({evt_valid, evt_dropped} !== 2'b00)
         begin n_bad++; $display("FAIL hs2 valid/dropped got %b%b exp 00", evt_valid, evt_dropped); end
      // Equal maxima: the earlier 180 (ts 33) is reported; drop flag already consumed.
      send(16'sd120); send(16'sd180); send(16'sd180); send(16'sd0);
      got_v = {evt_valid, evt_amp, evt_ts, evt_width, evt_dropped};
      exp_v = {1'b1, 16'sd180, 32'd33, 8'd3, 1'b0};
      n_cmp++; if (got_v !== exp_v) begin n_bad++; $display("FAIL evt3 got %h exp %h", got_v, exp_v); end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask

   task automatic test_cfg_reject();
      write_cfg(7'd12, 7'd8, 8'd33, 16'sd7);
      n_cmp++; if (cfg_err !== 1'b1)    begin n_bad++; $display("FAIL rej1_err got %b exp 1", cfg_err); end
      n_cmp++; if ({filt_k, filt_l} !== {7'd4, 7'd10})
         begin n_bad++; $display("FAIL rej1_kl got %0d/%0d exp 4/10", filt_k, filt_l); end
      n_cmp++; if (filt_clear !== 1'b0) begin n_bad++; $display("FAIL rej1_clear got %b exp 0", filt_clear); end
      tick();
      n_cmp++; if ({cfg_err, filt_clear, cfg_busy} !== 3'b000)
         begin n_bad++; $display("FAIL rej1_after got %b%b%b exp 000", cfg_err, filt_clear, cfg_busy); end
      write_cfg(7'd0, 7'd5, 8'd33, 16'sd7);
      n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL rej0_err got %b exp 1", cfg_err); end
      // Strongly negative sample must not cross a positive threshold.
      send(-16'sd30000); send(16'sd0);
      n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL signed_thr valid got %b exp 0", evt_valid); end
   endtask

   // Write during TRACK; l==k is the smallest legal l. New flush is 5+5+8 = 18 samples.
   task automatic test_cfg_during_track();
      send(16'sd200);
      write_cfg(7'd5, 7'd5, 8'd30, 16'sd150);
      n_cmp++; if ({filt_clear, evt_valid, cfg_busy, cfg_err} !== 4'b1010)
         begin n_bad++; $display("FAIL trk_wr clr/valid/busy/err got %b%b%b%b exp 1010", filt_clear, evt_valid, cfg_busy, cfg_err); end
      n_cmp++; if ({filt_k, filt_l, filt_m} !== {7'd5, 7'd5, 8'd30})
         begin n_bad++; $display("FAIL trk_wr regs got %0d/%0d/%0d exp 5/5/30", filt_k, filt_l, filt_m); end
      send(16'sd0);   // lands in CLEAR: not counted
      n_cmp++; if (filt_clear !== 1'b0) begin n_bad++; $display("FAIL trk_clear_len got %b exp 0", filt_clear); end
      for (int i = 0; i < 17; i++) send(16'sd0);
      n_cmp++; if (cfg_busy !== 1'b1) begin n_bad++; $display("FAIL reflush_17 got %b exp 1", cfg_busy); end
      send(16'sd0);
      n_cmp++; if ({cfg_busy, evt_valid} !== 2'b00)
         begin n_bad++; $display("FAIL reflush_18 busy/valid got %b%b exp 00", cfg_busy, evt_valid); end
      // 140 is below the new threshold 150; 200 at ts 20 is above.
      send(16'sd140); send(16'sd0);
      n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL new_thr valid got %b exp 0", evt_valid); end
      send(16'sd200); send(16'sd0);
      n_cmp++; if ({evt_valid, evt_amp, evt_ts} !== {1'b1, 16'sd200, 32'd20})
         begin n_bad++; $display("FAIL evt4 got %b/%0d/%0d exp 1/200/20", evt_valid, evt_amp, evt_ts); end
   endtask

   task automatic test_reset_during_emit();
      reset = 1'b1;
      tick();
      n_cmp++; if ({evt_valid, cfg_busy} !== 2'b00)
         begin n_bad++; $display("FAIL rst_emit valid/busy got %b%b exp 00", evt_valid, cfg_busy); end
      n_cmp++; if ({filt_k, filt_l, filt_m} !== {7'd4, 7'd10, 8'd20})
         begin n_bad++; $display("FAIL rst_emit regs got %0d/%0d/%0d exp 4/10/20", filt_k, filt_l, filt_m); end
      n_cmp++; if ({evt_amp, evt_ts} !== 48'd0)
         begin n_bad++; $display("FAIL rst_emit payload got %0d/%0d exp 0/0", evt_amp, evt_ts); end
      reset = 1'b0;
   endtask

   task automatic test_saturation();
      tick();   // IDLE -> CLEAR
      tick();   // CLEAR -> FLUSH
      for (int i = 0; i < 22; i++) send(16'sd0);
      n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL sat_flush busy got %b exp 0", cfg_busy); end
      for (int i = 0; i < 300; i++) send(16'sd500);
      send(16'sd0);
      n_cmp++; if ({evt_valid, evt_amp, evt_ts, evt_width, evt_dropped} !== {1'b1, 16'sd500, 32'd22, 8'd255, 1'b0})
         begin n_bad++; $display("FAIL sat_evt got %b/%0d/%0d/%0d/%b exp 1/500/22/255/0",
                                 evt_valid, evt_amp, evt_ts, evt_width, evt_dropped); end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL sat_hs valid got %b exp 0", evt_valid); end
   endtask

   initial begin
      reset = 1'b1; cfg_wr = 1'b0; cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_thr = '0;
      filt_valid = 1'b0; filt_data = '0; evt_ready = 1'b0;
      test_reset();
      test_config_flush();
      test_single_event();
      test_backpressure();
      test_cfg_reject();
      test_cfg_during_track();
      test_reset_during_emit();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
